// File: rtl/interrupt_control_pkg.sv
// interrupt_control_pkg: shared state encodings, opcodes and IOT decode types
package interrupt_control_pkg;
  localparam logic [4:0] F0 = 5'd0;
  localparam logic [4:0] F1 = 5'd1;
  localparam logic [5:0] DEV_PROC = 6'o00;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  typedef enum logic [2:0] {
    FN_SKON = 3'd0, FN_ION = 3'd1, FN_IOF = 3'd2, FN_SRQ = 3'd3,
    FN_GTF = 3'd4, FN_RTF = 3'd5, FN_SGT = 3'd6, FN_CAF = 3'd7
  } iot_fn_e;
  typedef struct packed {
    logic skon;
    logic ion;
    logic iof;
    logic srq;
    logic rtf;
    logic caf;
    logic cif;
  } iot_dec_t;
endpackage

// File: rtl/interrupt_control_iot_decode.sv
// iot_decode: combinational decode of processor IOTs (600x) and CIF (62x2/3/6/7)
module iot_decode
  import interrupt_control_pkg::*;
(
  input  logic [0:11] instruction_i,
  output iot_dec_t    dec_o
);
  logic    is_iot;
  logic    proc;
  iot_fn_e fn;
  always_comb begin
    is_iot     = instruction_i[0:2] == OP_IOT;
    proc       = is_iot && instruction_i[3:8] == DEV_PROC;
    fn         = iot_fn_e'(instruction_i[9:11]);
    dec_o.skon = proc && fn == FN_SKON;
    dec_o.ion  = proc && fn == FN_ION;
    dec_o.iof  = proc && fn == FN_IOF;
    dec_o.srq  = proc && fn == FN_SRQ;
    dec_o.rtf  = proc && fn == FN_RTF;
    dec_o.caf  = proc && fn == FN_CAF;
    dec_o.cif  = is_iot && instruction_i[3:5] == 3'd2 && instruction_i[10];
  end
endmodule

// File: rtl/interrupt_control.sv
// interrupt_control: ION/IOF/SKON/SRQ/RTF/CAF execution, ION delay, CIF inhibit and request sync
module interrupt_control
  import interrupt_control_pkg::*;
#(
  parameter int N_DEV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       state,
  input  logic [0:11]      instruction,
  input  logic             int_in_prog,
  input  logic [N_DEV-1:0] dev_req,
  output logic             int_ena,
  output logic             int_inh,
  output logic             int_req,
  output logic             skip,
  output logic             caf
);
  logic [4:0] prev_state_q;
  logic       int_ena_q, int_ena_d, int_inh_q, int_inh_d, int_req_q;
  logic       skip_q, skip_d, caf_q, caf_d;
  logic       ion_pend_q, ion_pend_d, armed_q, armed_d, jmp_seen_q, jmp_seen_d;
  logic       start, f1_entry;
  iot_dec_t   dec, stb;

  iot_decode u_dec (.instruction_i(instruction), .dec_o(dec));

  // Later assignments win, giving int_in_prog > CAF > IOF/SKON > ION/RTF > delayed enable.
  always_comb begin
    start      = state == F0 && prev_state_q != F0;
    f1_entry   = state == F1 && prev_state_q != F1;
    stb        = f1_entry ? dec : '0;
    int_ena_d  = int_ena_q;
    int_inh_d  = int_inh_q;
    ion_pend_d = ion_pend_q;
    armed_d    = armed_q;
    jmp_seen_d = state == F1 ? (instruction[0:2] == OP_JMS || instruction[0:2] == OP_JMP) : jmp_seen_q;
    if (start) begin
      armed_d    = ion_pend_q & ~armed_q;
      jmp_seen_d = 1'b0;
      int_inh_d  = jmp_seen_q ? 1'b0 : int_inh_q;
      if (armed_q && ion_pend_q) begin
        int_ena_d  = 1'b1;
        ion_pend_d = 1'b0;
      end
    end
    if (stb.ion || stb.rtf) ion_pend_d = 1'b1;
    if (stb.rtf || stb.cif) int_inh_d = 1'b1;
    if (stb.iof || stb.skon) {int_ena_d, ion_pend_d} = 2'b00;
    if (stb.caf) {int_ena_d, ion_pend_d, int_inh_d} = 3'b000;
    if (int_in_prog) {int_ena_d, ion_pend_d, armed_d} = 3'b000;
    skip_d = (stb.skon & int_ena_q) | (stb.srq & int_req_q);
    caf_d  = stb.caf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state_q <= '0;
      int_ena_q    <= 1'b0;
      int_inh_q    <= 1'b0;
      int_req_q    <= 1'b0;
      skip_q       <= 1'b0;
      caf_q        <= 1'b0;
      ion_pend_q   <= 1'b0;
      armed_q      <= 1'b0;
      jmp_seen_q   <= 1'b0;
    end else begin
      prev_state_q <= state;
      int_ena_q    <= int_ena_d;
      int_inh_q    <= int_inh_d;
      int_req_q    <= |dev_req;
      skip_q       <= skip_d;
      caf_q        <= caf_d;
      ion_pend_q   <= ion_pend_d;
      armed_q      <= armed_d;
      jmp_seen_q   <= jmp_seen_d;
    end
  end

  assign int_ena = int_ena_q;
  assign int_inh = int_inh_q;
  assign int_req = int_req_q;
  assign skip    = skip_q;
  assign caf     = caf_q;
endmodule

// File: tb/tb_interrupt_control.sv
// tb_interrupt_control: table-driven instruction stream plus hand sequences for reset and entry
module tb_interrupt_control;
  import interrupt_control_pkg::*;
  localparam logic [4:0] SE = 5'd2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  state = SE;
  logic [0:11] instruction = '0;
  logic        int_in_prog = 1'b0;
  logic [7:0]  dev_req = 8'hFF;
  logic        int_ena, int_inh, int_req, skip, caf;
  int          tests = 0, fails = 0;
  logic        ena_f0, inh_f0;
  int          nskip, ncaf;

  typedef struct {
    string       name;
    logic [11:0] ins;
    int          f1n;
    logic [7:0]  dev;
    logic        e_ena_f0, e_ena, e_inh_f0, e_inh;
    int          e_skip, e_caf;
  } vec_t;
  vec_t vq[$];

  interrupt_control #(.N_DEV(8)) dut (
    .clk(clk), .reset(reset), .state(state), .instruction(instruction),
    .int_in_prog(int_in_prog), .dev_req(dev_req), .int_ena(int_ena),
    .int_inh(int_inh), .int_req(int_req), .skip(skip), .caf(caf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [11:0] ins, input int f1n, input logic [7:0] dev);
    state = F0;
    instruction = ins;
    dev_req = dev;
    tick;
    ena_f0 = int_ena;
    inh_f0 = int_inh;
    nskip = int'(skip);
    ncaf = int'(caf);
    state = F1;
    repeat (f1n) begin
      tick;
      nskip += int'(skip);
      ncaf += int'(caf);
    end
    state = SE;
    tick;
    nskip += int'(skip);
    ncaf += int'(caf);
  endtask

  task automatic add(input string n, input logic [11:0] ins, input int f1n, input logic [7:0] dev,
                     input logic ef, input logic ee, input logic hf, input logic he, input int es, input int ec);
    vec_t v;
    v.name = n; v.ins = ins; v.f1n = f1n; v.dev = dev;
    v.e_ena_f0 = ef; v.e_ena = ee; v.e_inh_f0 = hf; v.e_inh = he; v.e_skip = es; v.e_caf = ec;
    vq.push_back(v);
  endtask

  initial begin
    //  name          ins       f1n dev    ena_f0 ena inh_f0 inh skip caf
    add("ion",        12'o6001, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("nop1",       12'o7000, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("nop2",       12'o7000, 1, 8'h00, 1, 1, 0, 0, 0, 0);
    add("skon_on",    12'o6000, 1, 8'h00, 1, 0, 0, 0, 1, 0);
    add("skon_off",   12'o6000, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("ion_step",   12'o6001, 3, 8'h00, 0, 0, 0, 0, 0, 0);
    add("iof",        12'o6002, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("iof_nop1",   12'o7000, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("iof_nop2",   12'o7000, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("cif",        12'o6212, 1, 8'h00, 0, 0, 0, 1, 0, 0);
    add("cif_nop",    12'o7000, 1, 8'h00, 0, 0, 1, 1, 0, 0);
    add("cif_tad",    12'o1100, 1, 8'h00, 0, 0, 1, 1, 0, 0);
    add("cif_jmp",    12'o5200, 1, 8'h00, 0, 0, 1, 1, 0, 0);
    add("jmp_next",   12'o7000, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("srq_none",   12'o6003, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("srq_req",    12'o6003, 1, 8'h10, 0, 0, 0, 0, 1, 0);
    add("rtf",        12'o6005, 1, 8'h00, 0, 0, 0, 1, 0, 0);
    add("rtf_nop1",   12'o7000, 1, 8'h00, 0, 0, 1, 1, 0, 0);
    add("rtf_nop2",   12'o7000, 1, 8'h00, 1, 1, 1, 1, 0, 0);
    add("caf",        12'o6007, 1, 8'h00, 1, 0, 1, 0, 0, 1);
    add("gtf",        12'o6004, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("not_cif",    12'o6201, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    add("cif_6206",   12'o6206, 1, 8'h00, 0, 0, 0, 1, 0, 0);
    add("cif_jms",    12'o4100, 1, 8'h00, 0, 0, 1, 1, 0, 0);
    add("jms_next",   12'o7000, 1, 8'h00, 0, 0, 0, 0, 0, 0);

    repeat (3) begin
      tick;
      chk("reset_outs", {int_ena, int_inh, int_req, skip, caf}, 0);
    end
    reset = 1'b0;
    tick;
    chk("req_after_reset", int_req, 1);
    dev_req = 8'h00;
    tick;
    chk("req_drop", int_req, 0);

    foreach (vq[i]) begin
      do_instr(vq[i].ins, vq[i].f1n, vq[i].dev);
      chk($sformatf("%s ena_f0", vq[i].name), ena_f0, vq[i].e_ena_f0);
      chk($sformatf("%s ena", vq[i].name), int_ena, vq[i].e_ena);
      chk($sformatf("%s inh_f0", vq[i].name), inh_f0, vq[i].e_inh_f0);
      chk($sformatf("%s inh", vq[i].name), int_inh, vq[i].e_inh);
      chk($sformatf("%s skip", vq[i].name), nskip, vq[i].e_skip);
      chk($sformatf("%s caf", vq[i].name), ncaf, vq[i].e_caf);
    end

    do_instr(12'o6001, 1, 8'h00);
    do_instr(12'o6002, 1, 8'h00);
    for (int k = 0; k < 10; k++) begin
      do_instr(12'o7000, 1, 8'h00);
      chk($sformatf("ion_iof nop%0d", k), {ena_f0, int_ena}, 0);
    end

    do_instr(12'o6001, 1, 8'h00);
    do_instr(12'o7000, 1, 8'h00);
    do_instr(12'o7000, 1, 8'h00);
    chk("entry ena_pre", int_ena, 1);
    do_instr(12'o6212, 1, 8'h00);
    dev_req = 8'h08;
    int_in_prog = 1'b1;
    tick;
    int_in_prog = 1'b0;
    chk("entry ena_clr", int_ena, 0);
    chk("entry req", int_req, 1);
    chk("entry inh_kept", int_inh, 1);
    do_instr(12'o6007, 1, 8'h08);
    chk("entry caf", ncaf, 1);
    chk("entry caf_inh", int_inh, 0);

    do_instr(12'o6001, 1, 8'h00);
    int_in_prog = 1'b1;
    tick;
    int_in_prog = 1'b0;
    do_instr(12'o7000, 1, 8'h00);
    do_instr(12'o7000, 1, 8'h00);
    chk("entry kills_pend", {ena_f0, int_ena}, 0);

    do_instr(12'o6001, 1, 8'h00);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    do_instr(12'o7000, 1, 8'h00);
    do_instr(12'o7000, 1, 8'h00);
    do_instr(12'o7000, 1, 8'h00);
    chk("reset kills_pend", {ena_f0, int_ena}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
